// File: rtl/gcn_pkg.sv
// rtl/gcn_pkg.sv - shared widths, types, state encoding and helpers for the GCN inference core
package gcn_pkg;

    localparam int FEATURE_COLS      = 96;
    localparam int WEIGHT_ROWS       = FEATURE_COLS;
    localparam int FEATURE_ROWS      = 6;
    localparam int WEIGHT_COLS       = 3;
    localparam int FEATURE_WIDTH     = 5;
    localparam int WEIGHT_WIDTH      = 5;
    localparam int DOT_PROD_WIDTH    = 16;
    localparam int ADDRESS_WIDTH     = 13;
    localparam int COO_NUM_OF_COLS   = 6;
    localparam int COO_NUM_OF_ROWS   = 2;
    localparam int COO_BW            = $clog2(COO_NUM_OF_COLS);
    localparam int MAX_ADDRESS_WIDTH = 2;
    localparam int NUM_OF_NODES      = FEATURE_ROWS;

    localparam logic [ADDRESS_WIDTH-1:0] FEATURE_BASE_ADDR = 13'h200;

    typedef logic [0:FEATURE_COLS-1][FEATURE_WIDTH-1:0] feat_row_t;
    typedef logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0]   weight_col_t;
    typedef logic [DOT_PROD_WIDTH-1:0]                  dot_t;
    typedef logic [MAX_ADDRESS_WIDTH-1:0]               class_idx_t;
    typedef logic [COO_BW-1:0]                          node_t;
    typedef logic [ADDRESS_WIDTH-1:0]                   addr_t;
    typedef logic [0:COO_NUM_OF_ROWS-1][COO_BW-1:0]     coo_edge_t;
    typedef logic [0:NUM_OF_NODES-1][MAX_ADDRESS_WIDTH-1:0] answer_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_F,
        ST_COMPUTE,
        ST_AGGREGATE,
        ST_ARGMAX,
        ST_DONE
    } state_t;

    // Strict greater-than keeps the lowest column on ties.
    function automatic class_idx_t argmax3(input dot_t a, input dot_t b, input dot_t c);
        class_idx_t idx;
        dot_t       best;
        idx  = 2'd0;
        best = a;
        if (b > best) begin
            idx  = 2'd1;
            best = b;
        end
        if (c > best) begin
            idx = 2'd2;
        end
        return idx;
    endfunction

endpackage

// File: rtl/gcn_if.sv
// rtl/gcn_if.sv - external memory bus: weight/feature read port and COO edge-list port
interface gcn_if;
    import gcn_pkg::*;

    addr_t     read_address;
    logic      enable_read;
    feat_row_t data_in;
    node_t     coo_address;
    coo_edge_t coo_in;

    modport master (
        output read_address,
        output enable_read,
        output coo_address,
        input  data_in,
        input  coo_in
    );

    modport slave (
        input  read_address,
        input  enable_read,
        input  coo_address,
        output data_in,
        output coo_in
    );

endinterface

// File: rtl/gcn_dot96.sv
// rtl/gcn_dot96.sv - combinational 96-term unsigned dot product, truncated to the product width
module gcn_dot96
    import gcn_pkg::*;
(
    input  feat_row_t   feat_i,
    input  weight_col_t weight_i,
    output dot_t        dot_o
);

    dot_t acc;

    always_comb begin
        acc = '0;
        for (int k = 0; k < FEATURE_COLS; k++) begin
            acc = acc + dot_t'(feat_i[k]) * dot_t'(weight_i[k]);
        end
    end

    assign dot_o = acc;

endmodule

// File: rtl/gcn_core.sv
// rtl/gcn_core.sv - GCN inference: load weights, per-row FM x WM, COO aggregation, per-node argmax
module gcn_core
    import gcn_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    gcn_if.master    mem,
    output logic     done,
    output answer_t  max_addi_answer
);

    state_t      state_q, state_d;
    node_t       cnt_q, cnt_d;
    logic [1:0]  col_q, col_d;
    addr_t       addr_q, addr_d;
    logic        en_q, en_d;
    node_t       coo_q, coo_d;
    logic        done_q, done_d;
    answer_t     ans_q, ans_d;

    weight_col_t w_q  [0:WEIGHT_COLS-1];
    feat_row_t   f_q;
    dot_t        fw_q [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
    dot_t        h_q  [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
    dot_t        h_inc[0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
    dot_t        dot;
    node_t       src, dst;
    logic        edge_ok;

    gcn_dot96 u_dot (
        .feat_i   (f_q),
        .weight_i (w_q[col_q]),
        .dot_o    (dot)
    );

    // Both endpoints of an edge pick up the other's FW row; a self edge adds its own row twice.
    always_comb begin
        src     = mem.coo_in[0];
        dst     = mem.coo_in[1];
        edge_ok = (src < node_t'(NUM_OF_NODES)) && (dst < node_t'(NUM_OF_NODES));
        for (int n = 0; n < NUM_OF_NODES; n++) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                h_inc[n][c] = '0;
                if (edge_ok && src == node_t'(n)) begin
                    h_inc[n][c] = h_inc[n][c] + fw_q[dst][c];
                end
                if (edge_ok && dst == node_t'(n)) begin
                    h_inc[n][c] = h_inc[n][c] + fw_q[src][c];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        addr_d  = addr_q;
        en_d    = 1'b0;
        coo_d   = coo_q;
        done_d  = done_q;
        ans_d   = ans_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_W;
                    cnt_d   = '0;
                    addr_d  = '0;
                    en_d    = 1'b1;
                end
            end
            ST_LOAD_W: begin
                if (cnt_q == node_t'(WEIGHT_COLS - 1)) begin
                    state_d = ST_LOAD_F;
                    cnt_d   = '0;
                    addr_d  = FEATURE_BASE_ADDR;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = addr_t'(cnt_q) + addr_t'(1);
                end
                en_d = 1'b1;
            end
            ST_LOAD_F: begin
                state_d = ST_COMPUTE;
                col_d   = '0;
            end
            ST_COMPUTE: begin
                if (col_q == 2'(WEIGHT_COLS - 1)) begin
                    col_d = '0;
                    if (cnt_q == node_t'(NUM_OF_NODES - 1)) begin
                        state_d = ST_AGGREGATE;
                        cnt_d   = '0;
                        coo_d   = '0;
                    end else begin
                        state_d = ST_LOAD_F;
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = FEATURE_BASE_ADDR + addr_t'(cnt_q) + addr_t'(1);
                        en_d    = 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_AGGREGATE: begin
                if (cnt_q == node_t'(COO_NUM_OF_COLS - 1)) begin
                    state_d = ST_ARGMAX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    coo_d = cnt_q + 1'b1;
                end
            end
            ST_ARGMAX: begin
                for (int n = 0; n < NUM_OF_NODES; n++) begin
                    ans_d[n] = argmax3(h_q[n][0], h_q[n][1], h_q[n][2]);
                end
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            coo_q   <= '0;
            done_q  <= 1'b0;
            ans_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            coo_q   <= coo_d;
            done_q  <= done_d;
            ans_q   <= ans_d;
        end
    end

    // Read data arrives one cycle after the request, so each load state captures the bus directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                w_q[c] <= '0;
            end
            f_q <= '0;
            for (int n = 0; n < NUM_OF_NODES; n++) begin
                for (int c = 0; c < WEIGHT_COLS; c++) begin
                    fw_q[n][c] <= '0;
                    h_q[n][c]  <= '0;
                end
            end
        end else begin
            case (state_q)
                ST_LOAD_W: w_q[cnt_q[1:0]] <= mem.data_in;
                ST_LOAD_F: f_q <= mem.data_in;
                ST_COMPUTE: begin
                    fw_q[cnt_q][col_q] <= dot;
                    h_q[cnt_q][col_q]  <= dot;
                end
                ST_AGGREGATE: begin
                    for (int n = 0; n < NUM_OF_NODES; n++) begin
                        for (int c = 0; c < WEIGHT_COLS; c++) begin
                            h_q[n][c] <= h_q[n][c] + h_inc[n][c];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.read_address = addr_q;
    assign mem.enable_read  = en_q;
    assign mem.coo_address  = coo_q;
    assign done             = done_q;
    assign max_addi_answer  = ans_q;

endmodule

// File: tb/tb_gcn_core.sv
// tb/tb_gcn_core.sv - scoreboard bench for gcn_core with a behavioural weight/feature/COO memory
module tb_gcn_core;
    import gcn_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    logic    start;
    logic    done;
    answer_t ans;

    gcn_if mem();

    gcn_core dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mem             (mem),
        .done            (done),
        .max_addi_answer (ans)
    );

    always #5 clk = ~clk;

    logic [4:0] w_mem [0:2][0:95];
    logic [4:0] f_mem [0:5][0:95];
    node_t      e_mem [0:5][0:1];

    int n_tests = 0;
    int n_fail  = 0;

    int   exp_q[$];
    int   addr_q[$];
    logic mon_on = 1'b0;
    int   en_count;
    logic [7:0] coo_seen;
    int   done_rises;
    logic done_prev;

    always_comb begin
        mem.data_in = '0;
        if (mem.read_address < 13'd3) begin
            for (int k = 0; k < 96; k++) mem.data_in[k] = w_mem[mem.read_address][k];
        end else if (mem.read_address >= 13'h200 && mem.read_address < 13'h206) begin
            for (int k = 0; k < 96; k++) mem.data_in[k] = f_mem[mem.read_address - 13'h200][k];
        end
        mem.coo_in[0] = (mem.coo_address < 3'd6) ? e_mem[mem.coo_address][0] : 3'd0;
        mem.coo_in[1] = (mem.coo_address < 3'd6) ? e_mem[mem.coo_address][1] : 3'd0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (mem.enable_read) begin
                en_count++;
                if (addr_q.size() > 0) check_eq("read_addr", 32'(mem.read_address), 32'(addr_q.pop_front()));
            end
            coo_seen[mem.coo_address] = 1'b1;
            if (done && !done_prev) done_rises++;
            done_prev = done;
        end
    end

    task automatic build_expected();
        int fw[6][3];
        int h[6][3];
        int s, d, acc, best;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 3; c++) begin
                acc = 0;
                for (int k = 0; k < 96; k++) acc += int'(f_mem[r][k]) * int'(w_mem[c][k]);
                fw[r][c] = acc & 32'hFFFF;
                h[r][c]  = fw[r][c];
            end
        end
        for (int e = 0; e < 6; e++) begin
            s = int'(e_mem[e][0]);
            d = int'(e_mem[e][1]);
            for (int c = 0; c < 3; c++) begin
                h[s][c] = (h[s][c] + fw[d][c]) & 32'hFFFF;
                h[d][c] = (h[d][c] + fw[s][c]) & 32'hFFFF;
            end
        end
        for (int n = 0; n < 6; n++) begin
            best = 0;
            for (int c = 1; c < 3; c++) if (h[n][c] > h[n][best]) best = c;
            exp_q.push_back(best);
        end
        for (int a = 0; a < 3; a++) addr_q.push_back(a);
        for (int r = 0; r < 6; r++) addr_q.push_back(32'h200 + r);
    endtask

    task automatic fill(input int w0, input int w1, input int w2, input int fv);
        for (int k = 0; k < 96; k++) begin
            w_mem[0][k] = 5'(w0);
            w_mem[1][k] = 5'(w1);
            w_mem[2][k] = 5'(w2);
            for (int r = 0; r < 6; r++) f_mem[r][k] = 5'(fv);
        end
        for (int e = 0; e < 6; e++) begin
            e_mem[e][0] = 3'd0;
            e_mem[e][1] = 3'd0;
        end
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        start  = 1'b0;
        reset  = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_case(input string tag);
        int      cycles;
        answer_t exp_ans;
        build_expected();
        en_count   = 0;
        coo_seen   = '0;
        done_rises = 0;
        done_prev  = 1'b0;
        mon_on     = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_latency_le64"}, 32'(cycles <= 64), 32'd1);
        exp_ans = '0;
        for (int n = 0; n < 6; n++) begin
            exp_ans[n] = 2'(exp_q.pop_front());
            check_eq($sformatf("%s_node%0d", tag, n), 32'(ans[n]), 32'(exp_ans[n]));
        end
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq({tag, "_held_ans"}, 32'(ans), 32'(exp_ans));
        check_eq({tag, "_held_done"}, 32'(done), 32'd1);
        check_eq({tag, "_reads"}, 32'(en_count), 32'd9);
        check_eq({tag, "_reads_left"}, 32'(addr_q.size()), 32'd0);
        check_eq({tag, "_coo_seen"}, 32'(coo_seen), 32'h3F);
        check_eq({tag, "_coo_last"}, 32'(mem.coo_address), 32'd5);
        check_eq({tag, "_done_rises"}, 32'(done_rises), 32'd1);
        mon_on = 1'b0;
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        int guard;
        reset = 1'b0;
        start = 1'b0;
        fill(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_en", 32'(mem.enable_read), 32'd0);
        check_eq("rst_addr", 32'(mem.read_address), 32'd0);
        check_eq("rst_coo", 32'(mem.coo_address), 32'd0);
        check_eq("rst_ans", 32'(ans), 32'd0);

        do_reset();
        fill(0, 0, 1, 1);
        run_case("col2");

        do_reset();
        fill(0, 0, 0, 1);
        run_case("zero_w");

        do_reset();
        fill(31, 31, 31, 31);
        run_case("ovf");

        do_reset();
        fill(0, 1, 0, 0);
        for (int k = 0; k < 96; k++) f_mem[1][k] = 5'd1;
        e_mem[2][0] = 3'd1;
        e_mem[2][1] = 3'd4;
        run_case("agg");

        do_reset();
        for (int k = 0; k < 96; k++) begin
            for (int c = 0; c < 3; c++) w_mem[c][k] = 5'($urandom_range(0, 31));
            for (int r = 0; r < 6; r++) f_mem[r][k] = 5'($urandom_range(0, 31));
        end
        for (int e = 0; e < 6; e++) begin
            e_mem[e][0] = 3'($urandom_range(0, 5));
            e_mem[e][1] = 3'($urandom_range(0, 5));
        end
        run_case("rand");

        do_reset();
        fill(0, 0, 1, 1);
        run_case("pre_abort");
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(mem.enable_read && mem.read_address == 13'h200) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("abort_reach_loadf", 32'(mem.read_address), 32'h200);
        reset = 1'b0;
        #1;
        check_eq("abort_en", 32'(mem.enable_read), 32'd0);
        check_eq("abort_addr", 32'(mem.read_address), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_ans", 32'(ans), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("abort_idle_en", 32'(mem.enable_read), 32'd0);
        run_case("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
